rgb_fade_controller: RTL and testbench
======================================

# rgb_fade_controller

Sequencer that owns the three 8-bit duty levels feeding the red/green/blue PWM channels. In MANUAL mode the levels follow the three encoder counts. In AUTO mode the block steps through a fixed four-colour preset table, fading each channel one LSB per tick and holding at each preset. It sits between the encoder counters and the PWM generators inside the mixer top level.

## Interface
- `TICK_DIV`, 1000, clocks per fade/hold tick (≥2)
- `HOLD_STEPS`, 255, ticks spent holding at each preset (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `enc0`  in  8  red encoder count
- `enc1`  in  8  green encoder count
- `enc2`  in  8  blue encoder count
- `auto_req`  in  1  single-cycle pulse, toggles MANUAL/AUTO
- `level0`  out  8  red duty to PWM
- `level1`  out  8  green duty to PWM
- `level2`  out  8  blue duty to PWM
- `auto_active`  out  1  high in FADE or HOLD
- `preset_idx`  out  2  current preset index

## Operation
- States: MANUAL, FADE, HOLD. Reset state is MANUAL.
- Preset table (r,g,b):
  - 0 = (FF,00,00)
  - 1 = (00,FF,00)
  - 2 = (00,00,FF)
  - 3 = (FF,FF,FF)
- MANUAL:
  - `levelN` <= `encN` every cycle.
  - `auto_req` -> FADE. On entry, `preset_idx`=0, tick counter and hold counter cleared, levels keep their current values.
- Tick: counter 0..TICK_DIV-1 in FADE/HOLD. Tick is asserted in the cycle where counter == TICK_DIV-1; counter then wraps to 0.
- FADE, on each tick:
  - If all three levels equal the preset target -> HOLD, hold counter=0, no level change.
  - Otherwise every channel not at target moves exactly 1 toward it (+1 or -1). Channels already at target are unchanged. Levels never wrap.
- HOLD, on each tick:
  - Hold counter increments.
  - When hold counter == HOLD_STEPS-1: `preset_idx` <= `preset_idx`+1 (3 wraps to 0), hold counter <= 0, -> FADE.
- FADE/HOLD, `auto_req` -> MANUAL. Levels load the encoder values on the next cycle.
- Encoder change detect: previous `enc0..2` registered every cycle in all states, reset to 0. A change is a mismatch between current and previous value on any channel.
- Simultaneous events:
  - `auto_req` takes priority over a tick in the same cycle.
  - In MANUAL, `auto_req` with an encoder change still enters FADE.

## Timing
- Reset values: `level0..2`=00, `auto_active`=0, `preset_idx`=0, state MANUAL, all counters 0.
- MANUAL latency: `encN` to `levelN` is 1 clock.
- `auto_req` sampled at edge k: state and `auto_active` change at edge k; first tick at edge k+TICK_DIV.
- Fade from level a to target b takes |a-b| ticks, plus 1 tick to detect completion.
- Hold lasts HOLD_STEPS ticks.
- Reset asserted mid-fade or mid-hold: all outputs go to reset values immediately, asynchronously. Operation resumes in MANUAL after reset is released.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `RGB_FADE_AUTO_EXIT_EN`
  - Defined: an encoder change detected while in FADE or HOLD forces MANUAL. Levels load the encoder values 1 cycle later. If `auto_req` occurs in the same cycle, the result is MANUAL.
  - Undefined: encoder inputs are ignored in FADE/HOLD (change-detect registers still update), and only `auto_req` exits AUTO.

## Test plan
- Reset, then `enc0`=10, `enc1`=20, `enc2`=30 in MANUAL -> levels 10/20/30 one clock later; `auto_active`=0.
- TICK_DIV=4, HOLD_STEPS=2, levels (FE,00,00), pulse `auto_req` -> `level0`=FF after 1 tick (4 clk). FADE->HOLD on tick 2. `preset_idx`=1 at tick 4. `level0`=FE and `level1`=01 at tick 5.
- Auto run with TICK_DIV=2, HOLD_STEPS=1 for more than 4 presets -> `preset_idx` sequence 0,1,2,3,0. Levels never exceed FF or wrap below 00.
- Assert `reset` low mid-fade with `level1`=80 -> all levels 00, `preset_idx`=0, `auto_active`=0 immediately, with no clock edge required.
- Macro defined, in HOLD, change `enc2` 00->05 -> MANUAL next edge; `level2`=05 one clock later. Macro undefined, same stimulus -> remains in HOLD, levels unchanged.
- `auto_req` in FADE coincident with a tick -> MANUAL, no level step applied; levels equal encoder values the following cycle.

Source files
------------

// File: rtl/rgb_fade_controller.sv
// rtl/rgb_fade_controller.sv - RGB duty sequencer: manual encoder follow or automatic preset fade/hold
// Optional macro RGB_FADE_AUTO_EXIT_EN: encoder movement during FADE/HOLD returns to MANUAL.
module rgb_fade_controller #(
    parameter int TICK_DIV   = 1000,
    parameter int HOLD_STEPS = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] enc0,
    input  logic [7:0] enc1,
    input  logic [7:0] enc2,
    input  logic       auto_req,
    output logic [7:0] level0,
    output logic [7:0] level1,
    output logic [7:0] level2,
    output logic       auto_active,
    output logic [1:0] preset_idx
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        FADE   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt;
    logic          tick;
    logic          exit_req;
    logic          at_target;
    logic [7:0]    tgt0;
    logic [7:0]    tgt1;
    logic [7:0]    tgt2;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            return cur + 8'd1;
        else if (cur > tgt)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    // Presets 0..2 light one channel each; preset 3 is white.
    always_comb begin
        tgt0 = (preset_idx == 2'd0 || preset_idx == 2'd3) ? 8'hFF : 8'h00;
        tgt1 = (preset_idx == 2'd1 || preset_idx == 2'd3) ? 8'hFF : 8'h00;
        tgt2 = (preset_idx == 2'd2 || preset_idx == 2'd3) ? 8'hFF : 8'h00;
        at_target = (level0 == tgt0) && (level1 == tgt1) && (level2 == tgt2);
        tick = (tick_cnt == TICK_LAST);
    end

`ifdef RGB_FADE_AUTO_EXIT_EN
    logic [7:0] prev0;
    logic [7:0] prev1;
    logic [7:0] prev2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev0 <= 8'h00;
            prev1 <= 8'h00;
            prev2 <= 8'h00;
        end else begin
            prev0 <= enc0;
            prev1 <= enc1;
            prev2 <= enc2;
        end
    end

    assign exit_req = auto_req || (enc0 != prev0) || (enc1 != prev1) || (enc2 != prev2);
`else
    assign exit_req = auto_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MANUAL;
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            level0      <= 8'h00;
            level1      <= 8'h00;
            level2      <= 8'h00;
            auto_active <= 1'b0;
            preset_idx  <= 2'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            case (state)
                MANUAL: begin
                    tick_cnt <= '0;
                    if (auto_req) begin
                        state       <= FADE;
                        auto_active <= 1'b1;
                        preset_idx  <= 2'd0;
                        hold_cnt    <= '0;
                    end else begin
                        level0 <= enc0;
                        level1 <= enc1;
                        level2 <= enc2;
                    end
                end
                FADE: begin
                    // Exit requests win over a coincident tick.
                    if (exit_req) begin
                        state       <= MANUAL;
                        auto_active <= 1'b0;
                    end else if (tick) begin
                        if (at_target) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            level0 <= step_toward(level0, tgt0);
                            level1 <= step_toward(level1, tgt1);
                            level2 <= step_toward(level2, tgt2);
                        end
                    end
                end
                HOLD: begin
                    if (exit_req) begin
                        state       <= MANUAL;
                        auto_active <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            preset_idx <= preset_idx + 2'd1;
                            hold_cnt   <= '0;
                            state      <= FADE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= MANUAL;
                    auto_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_fade_controller.sv
// tb/tb_rgb_fade_controller.sv - randomized and directed checks of rgb_fade_controller against a behavioural model
module tb_rgb_fade_controller;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] enc [3];
    logic       auto_req;

    logic [7:0] a_l0, a_l1, a_l2, b_l0, b_l1, b_l2;
    logic       a_act, b_act;
    logic [1:0] a_idx, b_idx;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rgb_fade_controller #(.TICK_DIV(4), .HOLD_STEPS(2)) dut_a (
        .clk(clk), .reset(rst_a), .enc0(enc[0]), .enc1(enc[1]), .enc2(enc[2]),
        .auto_req(auto_req), .level0(a_l0), .level1(a_l1), .level2(a_l2),
        .auto_active(a_act), .preset_idx(a_idx)
    );

    rgb_fade_controller #(.TICK_DIV(2), .HOLD_STEPS(1)) dut_b (
        .clk(clk), .reset(rst_b), .enc0(enc[0]), .enc1(enc[1]), .enc2(enc[2]),
        .auto_req(auto_req), .level0(b_l0), .level1(b_l1), .level2(b_l2),
        .auto_active(b_act), .preset_idx(b_idx)
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: one slot per DUT instance.
    int td [2] = '{4, 2};
    int hs [2] = '{2, 1};
    bit m_auto [2];
    bit m_hold [2];
    int m_idx  [2];
    int m_cyc  [2];
    int m_hcnt [2];
    int m_lvl  [2][3];
    int m_prev [2][3];

    function automatic int target(input int idx, input int ch);
        return (idx == 3 || idx == ch) ? 255 : 0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!((i == 0) ? rst_a : rst_b)) begin
                m_auto[i] = 0; m_hold[i] = 0; m_idx[i] = 0; m_cyc[i] = 0; m_hcnt[i] = 0;
                for (int c = 0; c < 3; c++) begin m_lvl[i][c] = 0; m_prev[i][c] = 0; end
            end else begin
                bit chg;
                bit tick_now;
                bit done;
                chg = 0;
                for (int c = 0; c < 3; c++) if (int'(enc[c]) != m_prev[i][c]) chg = 1;
                if (!m_auto[i]) begin
                    if (auto_req) begin
                        m_auto[i] = 1; m_hold[i] = 0; m_idx[i] = 0; m_cyc[i] = 0; m_hcnt[i] = 0;
                    end else begin
                        for (int c = 0; c < 3; c++) m_lvl[i][c] = int'(enc[c]);
                    end
                end else begin
                    m_cyc[i]++;
                    tick_now = (m_cyc[i] % td[i]) == 0;
`ifdef RGB_FADE_AUTO_EXIT_EN
                    if (auto_req || chg) m_auto[i] = 0;
`else
                    if (auto_req) m_auto[i] = 0;
`endif
                    else if (tick_now) begin
                        if (!m_hold[i]) begin
                            done = 1;
                            for (int c = 0; c < 3; c++) if (m_lvl[i][c] != target(m_idx[i], c)) done = 0;
                            if (done) begin
                                m_hold[i] = 1; m_hcnt[i] = 0;
                            end else begin
                                for (int c = 0; c < 3; c++) begin
                                    if (m_lvl[i][c] < target(m_idx[i], c)) m_lvl[i][c]++;
                                    else if (m_lvl[i][c] > target(m_idx[i], c)) m_lvl[i][c]--;
                                end
                            end
                        end else begin
                            m_hcnt[i]++;
                            if (m_hcnt[i] == hs[i]) begin
                                m_idx[i] = (m_idx[i] + 1) % 4; m_hold[i] = 0; m_hcnt[i] = 0;
                            end
                        end
                    end
                end
                for (int c = 0; c < 3; c++) m_prev[i][c] = int'(enc[c]);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [26:0] act_v;
            logic [26:0] exp_v;
            act_v = (i == 0) ? {a_l0, a_l1, a_l2, a_act, a_idx} : {b_l0, b_l1, b_l2, b_act, b_idx};
            exp_v = {m_lvl[i][0][7:0], m_lvl[i][1][7:0], m_lvl[i][2][7:0], m_auto[i], m_idx[i][1:0]};
            chk((i == 0) ? "model_a" : "model_b", int'(act_v), int'(exp_v));
        end
    end

    int bq [$];
    always @(negedge clk) begin
        if (rst_b && b_act && (bq.size() == 0 || int'(b_idx) != bq[$]))
            bq.push_back(int'(b_idx));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        auto_req = 1'b1;
        @(negedge clk);
        auto_req = 1'b0;
    endtask

    task automatic set_enc(input int r, input int g, input int b);
        enc[0] = r[7:0]; enc[1] = g[7:0]; enc[2] = b[7:0];
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int waited;
        rst_a = 1'b0; rst_b = 1'b0; auto_req = 1'b0;
        set_enc(0, 0, 0);
        step(2);
        chk("reset_levels", int'({a_l0, a_l1, a_l2}), 0);
        chk("reset_active_idx", int'({a_act, a_idx}), 0);
        rst_a = 1'b1; rst_b = 1'b1;
        set_enc(8'h10, 8'h20, 8'h30);
        step(1);
        chk("manual_follow", int'({a_l0, a_l1, a_l2}), 24'h102030);
        chk("manual_inactive", int'(a_act), 0);

        set_enc(8'hFE, 0, 0);
        step(2);
        pulse();
        step(4);
        chk("tick1_level0", int'(a_l0), 8'hFF);
        step(12);
        chk("tick4_preset", int'(a_idx), 1);
        step(4);
        chk("tick5_levels", int'({a_l0, a_l1}), 16'hFE01);
        step(508);
        chk("midfade_level1", int'(a_l1), 8'h80);

        #3 rst_a = 1'b0;
        #1;
        chk("async_reset_levels", int'({a_l0, a_l1, a_l2}), 0);
        chk("async_reset_state", int'({a_act, a_idx}), 0);
        step(2);
        rst_a = 1'b1;

        waited = 0;
        while (bq.size() < 5 && waited < 4000) begin step(1); waited++; end
        chk("b_seq_len_ok", int'(bq.size() >= 5), 1);
        for (int k = 0; k < 5 && k < bq.size(); k++) chk("b_preset_seq", bq[k], exp_seq[k]);

        set_enc(8'h10, 8'h20, 8'h30);
        step(2);
        pulse();
        step(3);
        auto_req = 1'b1;
        set_enc(8'h40, 8'h50, 8'h60);
        step(1);
        auto_req = 1'b0;
        chk("coincident_no_step", int'({a_l0, a_l1, a_l2}), 24'h102030);
        chk("coincident_manual", int'(a_act), 0);
        step(1);
        chk("coincident_reload", int'({a_l0, a_l1, a_l2}), 24'h405060);

        set_enc(8'hFF, 0, 0);
        step(2);
        pulse();
        step(5);
        enc[2] = 8'h05;
        step(1);
`ifdef RGB_FADE_AUTO_EXIT_EN
        chk("enc_exit_active", int'(a_act), 0);
        step(1);
        chk("enc_exit_level2", int'(a_l2), 8'h05);
`else
        chk("enc_ignored_active", int'(a_act), 1);
        step(1);
        chk("enc_ignored_level2", int'({a_act, a_l2}), 9'h100);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) enc[$urandom_range(0, 2)] = 8'($urandom);
            if ($urandom_range(0, 299) == 0) pulse();
            else step(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
